// File: rtl/eq_run_detector_if.sv
// Valid/ready bundle between the comparator, the run detector and the hit consumer.
// The master side drives samples and hit acceptance; the slave side is the detector.
interface eq_run_detector_if;
    logic in_valid;
    logic in_ready;
    logic eq;
    logic hit_valid;
    logic hit_ready;

    modport master (
        output in_valid,
        output eq,
        output hit_ready,
        input  in_ready,
        input  hit_valid
    );

    modport slave (
        input  in_valid,
        input  eq,
        input  hit_ready,
        output in_ready,
        output hit_valid
    );
endinterface

// File: rtl/eq_run_detector.sv
// Counts consecutive eq=1 samples and raises a held hit after RUN_LEN of them.
// Define EQ_RUN_STATS_EN to add the saturating match/mismatch counters.
module eq_run_detector #(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    eq_run_detector_if.slave bus,
    output logic [CNT_W-1:0] run_cnt,
    output logic [CNT_W-1:0] hit_cnt
`ifdef EQ_RUN_STATS_EN
    ,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] mismatch_cnt
`endif
);

    typedef enum logic {
        SEARCH = 1'b0,
        HIT    = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] ALL1 = '1;

    state_t state_q;
    state_t state_d;
    logic   accept;
    logic   done;

    // Handshakes use the registered state, so no input reaches an output.
    assign accept = bus.in_valid && (state_q == SEARCH);
    assign done   = bus.hit_ready && (state_q == HIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = SEARCH;
        end else begin
            unique case (1'b1)
                (state_q == SEARCH): begin
                    if (accept && bus.eq && run_cnt == LAST) state_d = HIT;
                end
                (state_q == HIT): begin
                    if (bus.hit_ready) state_d = SEARCH;
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == SEARCH);
        bus.hit_valid = (state_q == HIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
        end else if (clear) begin
            run_cnt <= '0;
        end else if (accept) begin
            run_cnt <= bus.eq ? run_cnt + 1'b1 : '0;
        end else if (done) begin
            run_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt <= '0;
        end else if (clear) begin
            hit_cnt <= '0;
        end else if (done && hit_cnt != ALL1) begin
            hit_cnt <= hit_cnt + 1'b1;
        end
    end

`ifdef EQ_RUN_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt    <= '0;
            mismatch_cnt <= '0;
        end else if (clear) begin
            match_cnt    <= '0;
            mismatch_cnt <= '0;
        end else if (accept) begin
            if (bus.eq && match_cnt != ALL1) begin
                match_cnt <= match_cnt + 1'b1;
            end
            if (!bus.eq && mismatch_cnt != ALL1) begin
                mismatch_cnt <= mismatch_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
